// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the single-precision datapath
// (integer converter, adder and later normalisation stages).
package fp_pkg;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam int FP_BIAS   = 127;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

    // Exponent of a 32-bit integer whose top set bit is bit 31.
    localparam logic [FP_EXP_W-1:0] I2F_EXP_TOP = FP_EXP_W'(FP_BIAS + 31);
endpackage

// File: rtl/int_to_fp_if.sv
// Stream interface of the integer-to-float converter: one word in, one float out.
interface int_to_fp_if;
    import fp_pkg::*;

    logic        in_vld;
    logic [31:0] in_data;
    logic        out_vld;
    fp32_t       out_data;

    modport master (output in_vld, in_data, input out_vld, out_data);
    modport slave  (input in_vld, in_data, output out_vld, out_data);
endinterface

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter built as a byte-level
// priority tree; output is don't-care (31) for an all-zero input.
module lzc32 (
    input  logic [31:0] din,
    output logic [4:0]  cnt
);
    logic [3:0]      nz;
    logic [3:0][2:0] bcnt;

    // Level 1: per-byte presence flag and leading-zero count.
    always_comb begin
        nz   = '0;
        bcnt = '0;
        for (int b = 0; b < 4; b++) begin
            nz[b]   = |din[8*b +: 8];
            bcnt[b] = 3'd7;
            for (int i = 0; i < 8; i++)
                if (din[8*b + i]) bcnt[b] = 3'(7 - i);
        end
    end

    // Level 2: the most significant non-empty byte wins (scanned last).
    always_comb begin
        cnt = 5'd31;
        for (int b = 0; b < 4; b++)
            if (nz[b]) cnt = {2'(3 - b), bcnt[b]};
    end
endmodule

// File: rtl/int_to_fp.sv
// 4-stage pipelined int32 -> IEEE-754 single converter, round-to-nearest-even.
// Stages: sign/magnitude, leading-zero count, normalise, round and pack.
module int_to_fp
    import fp_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    int_to_fp_if.slave io
);
    localparam int STAGES = 4;

    logic [STAGES:1] vld_pipe;

    logic        s1_sign, s1_zero;
    logic [31:0] s1_mag;
    logic        s2_sign, s2_zero;
    logic [31:0] s2_mag;
    logic [4:0]  s2_lz;
    logic        s3_sign, s3_zero;
    logic [30:0] s3_frac;
    logic [7:0]  s3_exp;

    logic [4:0]  lz;
    logic        g, s, l, round_up;
    logic [23:0] mant_inc;
    fp32_t       res;

    lzc32 u_lzc (.din(s1_mag), .cnt(lz));

    // Only valid bits carry reset; a word presented during rst is dropped.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], io.in_vld};
    end

    assign io.out_vld = vld_pipe[STAGES];

    // Data advances every cycle; -2^31 negates to itself, which is the right magnitude.
    always_ff @(posedge clk) begin
        s1_sign <= SIGNED & io.in_data[31];
        s1_mag  <= (SIGNED && io.in_data[31]) ? -io.in_data : io.in_data;
        s1_zero <= (io.in_data == 32'd0);

        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_mag  <= s1_mag;
        s2_lz   <= lz;

        s3_sign <= s2_sign;
        s3_zero <= s2_zero;
        s3_frac <= 31'(s2_mag << s2_lz);
        s3_exp  <= I2F_EXP_TOP - {3'b000, s2_lz};
    end

    always_comb begin
        g        = s3_frac[7];
        s        = |s3_frac[6:0];
        l        = s3_frac[8];
        round_up = g & (s | l);
        mant_inc = {1'b0, s3_frac[30:8]} + 24'd1;
        res      = '{sign: s3_sign, exp: s3_exp, mant: s3_frac[30:8]};
        if (round_up) begin
            res.mant = mant_inc[22:0];
            if (mant_inc[23]) res.exp = s3_exp + 8'd1;
        end
        if (s3_zero) res = '0;
    end

    // out_data holds between valid words so consumers see a stable bus.
    always_ff @(posedge clk) begin
        if (rst)                  io.out_data <= '0;
        else if (vld_pipe[STAGES-1]) io.out_data <= res;
    end
endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp: table vectors, latency/reset sequences
// and a randomized stream against an arithmetic reference model.
module tb_int_to_fp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_to_fp_if ifs ();
    int_to_fp_if ifu ();

    int_to_fp #(.SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst), .io(ifs));
    int_to_fp #(.SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .io(ifu));

    typedef struct {
        logic        vld;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic [31:0] data;
        bit          sgn;
        logic [31:0] expect_bits;
    } vec_t;

    ent_t        q[$];
    logic [31:0] last_s, last_u;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: exact integer value rounded to 24 significant bits, ties to even.
    function automatic logic [31:0] ref_conv(input logic [31:0] x, input bit sgn);
        longint m, qm, rem, half;
        int     e, sh;
        bit     neg;
        m   = sgn ? longint'($signed(x)) : longint'(x);
        neg = (m < 0);
        if (neg) m = -m;
        if (m == 0) return 32'h0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e <= 23) qm = m << (23 - e);
        else begin
            sh   = e - 23;
            qm   = m >> sh;
            rem  = m - (qm << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && qm[0])) qm++;
            if (qm == (longint'(1) << 24)) begin
                qm = qm >> 1;
                e++;
            end
        end
        return {neg, 8'(e + 127), qm[22:0]};
    endfunction

    // One clock: drive, wait for the edge, then compare both DUTs with the model.
    task automatic tick(input logic r, input logic v, input logic [31:0] d);
        logic ev;
        rst = r;
        ifs.in_vld = v; ifs.in_data = d;
        ifu.in_vld = v; ifu.in_data = d;
        @(posedge clk);
        #1;
        ev = 1'b0;
        if (r) begin
            q.delete();
            last_s = '0;
            last_u = '0;
        end else begin
            q.push_back('{v, d});
            if (q.size() > 4) void'(q.pop_front());
            if (q.size() == 4 && q[0].vld) begin
                ev     = 1'b1;
                last_s = ref_conv(q[0].data, 1'b1);
                last_u = ref_conv(q[0].data, 1'b0);
            end
        end
        chk("vld_s", {31'b0, ifs.out_vld}, {31'b0, ev});
        chk("data_s", ifs.out_data, last_s);
        chk("vld_u", {31'b0, ifu.out_vld}, {31'b0, ev});
        chk("data_u", ifu.out_data, last_u);
    endtask

    vec_t vecs[$];
    int   lat;
    logic [31:0] w;

    initial begin
        vecs = '{
            '{32'h0000_0001, 1'b1, 32'h3F80_0000},
            '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000},
            '{32'h0000_0000, 1'b1, 32'h0000_0000},
            '{32'h8000_0000, 1'b1, 32'hCF00_0000},
            '{32'h7FFF_FFFF, 1'b1, 32'h4F00_0000},
            '{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000},
            '{32'h8000_0000, 1'b0, 32'h4F00_0000},
            '{32'h0000_0000, 1'b0, 32'h0000_0000},
            '{32'd16777217,  1'b1, 32'h4B80_0000},
            '{32'd16777219,  1'b1, 32'h4B80_0002},
            '{32'd16777221,  1'b1, 32'h4B80_0002},
            '{32'h00FF_FFFF, 1'b1, 32'h4B7F_FFFF},
            '{32'd3,         1'b1, 32'h4040_0000},
            '{32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000}
        };

        repeat (3) tick(1'b1, 1'b0, 32'h0);
        chk("reset_vld", {31'b0, ifs.out_vld}, 32'h0);
        chk("reset_data", ifs.out_data, 32'h0);

        foreach (vecs[i]) begin
            tick(1'b0, 1'b1, vecs[i].data);
            repeat (3) tick(1'b0, 1'b0, 32'h0);
            if (vecs[i].sgn) begin
                chk($sformatf("vec%0d_vld", i), {31'b0, ifs.out_vld}, 32'h1);
                chk($sformatf("vec%0d", i), ifs.out_data, vecs[i].expect_bits);
            end else begin
                chk($sformatf("vec%0d_vld", i), {31'b0, ifu.out_vld}, 32'h1);
                chk($sformatf("vec%0d", i), ifu.out_data, vecs[i].expect_bits);
            end
        end

        // Latency: count edges from capture until out_vld, bounded.
        tick(1'b0, 1'b1, 32'd1);
        lat = 0;
        for (int n = 2; n <= 9; n++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (ifs.out_vld && lat == 0) lat = n;
        end
        chk("latency", 32'(lat), 32'd4);

        // Reset mid-stream with three words in flight and one offered during rst.
        tick(1'b0, 1'b1, 32'd100);
        tick(1'b0, 1'b1, 32'd200);
        tick(1'b0, 1'b1, 32'd300);
        tick(1'b1, 1'b1, 32'd400);
        for (int n = 0; n < 4; n++) begin
            tick(1'b0, 1'b0, 32'h0);
            chk("rst_flush_vld", {31'b0, ifs.out_vld}, 32'h0);
            chk("rst_flush_data", ifs.out_data, 32'h0);
        end
        tick(1'b0, 1'b1, 32'd7);
        repeat (3) tick(1'b0, 1'b0, 32'h0);
        chk("post_rst_vld", {31'b0, ifs.out_vld}, 32'h1);
        chk("post_rst_data", ifs.out_data, 32'h40E0_0000);

        // Chained operands for the adder, back-to-back.
        tick(1'b0, 1'b1, 32'd3);
        tick(1'b0, 1'b1, 32'hFFFF_FFFB);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        chk("chain_a", ifs.out_data, 32'h4040_0000);
        tick(1'b0, 1'b0, 32'h0);
        chk("chain_b", ifs.out_data, 32'hC0A0_0000);

        // Random stream: back-to-back with random gaps, occasional extreme values.
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) tick(1'b0, 1'b0, $urandom);
            case ($urandom_range(0, 7))
                0:       w = 32'h8000_0000;
                1:       w = 32'h7FFF_FFFF;
                2:       w = $urandom & 32'h00FF_FFFF;
                3:       w = 32'h0100_0000 | ($urandom & 32'hF);
                default: w = $urandom;
            endcase
            tick(1'b0, 1'b1, w);
        end
        repeat (5) tick(1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_to_fp.md
# int_to_fp

Pipelined converter from 32-bit integer to IEEE-754 single precision with round-to-nearest-even. It is the front-end stage of the floating-point datapath. Integer sample streams such as ADC words and counters are converted here and then fed straight into the adder's `in_vld`/`a`/`b` inputs. It is fully pipelined, accepts one word per cycle and has no backpressure.

## Interface
- `SIGNED`, default 1: 1 treats `in_data` as two's complement; 0 treats it as unsigned.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `in_vld` input, 1 bit: `in_data` is valid this cycle.
- `in_data` input, 32 bits: integer operand.
- `out_vld` output, 1 bit: `out_data` is valid this cycle.
- `out_data` output, 32 bits: IEEE-754 single, laid out as {sign, exp[7:0], mant[22:0]}.

## Operation
- **Stage 1, sign and magnitude.**
  - When `SIGNED`=1: `sign` = `in_data[31]`, and `mag` = |`in_data`| as 32-bit unsigned.
  - -2^31 gives `mag` = 0x80000000; no overflow.
  - When `SIGNED`=0: `sign` = 0 and `mag` = `in_data`.
  - `zero` = (`mag` == 0).
- **Stage 2, leading-zero count.** `lz` = leading-zero count of `mag`, range 0..31. The value is don't-care when `zero`=1.
- **Stage 3, normalise.**
  - `norm` = `mag` << `lz`, so `norm[31]` = 1.
  - `exp` = 158 − `lz`, computed as 8-bit unsigned. 158 = bias 127 + 31.
- **Stage 4, round and pack.**
  - `mant` = `norm[30:8]`, `g` = `norm[7]`, `s` = OR(`norm[6:0]`), `l` = `norm[8]`.
  - Round up when `g` & (`s` | `l`).
  - If the incremented mantissa carries out, `mant` = 0 and `exp` = `exp` + 1.
  - `out_data` = {`sign`, `exp`, `mant`}.
- **Zero.** A zero input always produces 0x00000000, i.e. +0. The sign is forced to 0.
- **Range.** The maximum exponent is 159, reached when unsigned 0xFFFFFFFF rounds up to 2^32. No Inf, NaN or subnormal output can occur, so no special-case encodings exist.
- **Exactness.** Magnitudes below 2^24 convert exactly, since `g` = `s` = 0.
- **Data path and reset.**
  - Data registers carry no reset.
  - Only the valid pipeline and the output registers are reset.

## Timing
- Latency is 4 cycles: `in_vld` high in cycle N gives `out_vld` high in cycle N+4, with the matching `out_data`.
- Throughput is 1 word per cycle. Back-to-back inputs produce back-to-back outputs in order.
- Gaps in `in_vld` are preserved exactly in `out_vld`.
- While `out_vld`=0, `out_data` holds its last value. Consumers must qualify `out_data` with `out_vld`.
- Valid is a 4-bit shift register, reset to 0. Data advances every cycle regardless of valid.
- **Reset values:** `out_vld` = 0 and `out_data` = 0x00000000.
- **Reset mid-stream:** all in-flight words are discarded, and `out_vld` stays 0 for 4 cycles after `rst` deasserts unless new inputs arrive.
- **Input during reset:** `in_vld` asserted in the same cycle as `rst` is dropped.

## Structure
- Shared package `fp_pkg`, also used by the adder:
  - `FP_EXP_W`=8, `FP_MANT_W`=23, `FP_BIAS`=127.
  - typedef `fp32_t` as a packed struct {`sign`, `exp`, `mant`}.
- Sub-module `lzc32`: combinational 32-bit leading-zero counter producing a 5-bit count. Implement it as a 2-level priority tree and reuse it for later normalisation work.
- Everything else lives in `int_to_fp`: the 4 pipeline stage registers and the valid shift register.

## Test plan
- **Basic values.** Signed inputs 1, −1 and 0 give 0x3F800000, 0xBF800000 and 0x00000000. `out_vld` rises exactly 4 cycles after `in_vld`.
- **Extremes.** Signed 0x80000000 (−2^31) gives 0xCF000000. Signed 0x7FFFFFFF rounds to 0x4F000000. With `SIGNED`=0, 0xFFFFFFFF gives 0x4F800000, which exercises mantissa carry-out into the exponent.
- **RNE ties.** 16777217 gives 0x4B800000 (round down to even). 16777219 gives 0x4B800002 (round up to even). 16777221 gives 0x4B800002 (tie, LSB even, hold).
- **Streaming.** 1000 random signed words, back-to-back and with random `in_vld` gaps, are compared against a `$shortrealtobits(shortreal'(x))` reference. Output order and the gap pattern must match.
- **Reset mid-stream.** Assert `rst` for 1 cycle while 3 words are in flight. None of them appear and `out_vld`/`out_data` read 0. A word injected right after reset emerges 4 cycles later.
- **Chained into the adder.** The converter drives the adder with `a` = conv(3) and `b` = conv(−5), giving a sum of 0xC0000000 (−2.0).
